// File: rtl/irq_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : irq_ctrl_pkg
//  Description : Shared constants, types and helpers for the external
//                interrupt controller (FSM encodings, line modes, priority).
//  Revision    : 1.0 - initial release
// ============================================================================
package irq_ctrl_pkg;

    // Controller FSM encodings
    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_REQ  = 2'd1;
    localparam logic [1:0] c_ST_ACK  = 2'd2;

    // mcause code reported for interrupt line 0 unless overridden
    localparam int unsigned c_CAUSE_BASE_DEFAULT = 16;

    // Line-select width: covers the 16-line maximum
    localparam int c_SEL_W = 4;

    // Per-line latching mode
    typedef enum logic [0:0] {
        LINE_LEVEL = 1'b0,
        LINE_EDGE  = 1'b1
    } line_mode_e;

    // Index of the lowest set bit (highest priority); 0 when none set
    function automatic logic [c_SEL_W-1:0] f_lowest_set(input logic [15:0] i_vec);
        logic [c_SEL_W-1:0] idx;
        idx = '0;
        for (int i = 15; i >= 0; i--) begin
            if (i_vec[i]) begin
                idx = c_SEL_W'(i);
            end
        end
        return idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/irq_ctrl_sync.sv
`default_nettype none
// ============================================================================
//  Module      : irq_ctrl_sync
//  Description : One interrupt line: multi-flop synchroniser, falling-edge
//                detector and pending bit (edge latched or level following).
//  Revision    : 1.0 - initial release
// ============================================================================
module irq_ctrl_sync
    import irq_ctrl_pkg::*;
#(
    parameter int         SYNC_STAGES = 2,
    parameter line_mode_e MODE        = LINE_EDGE
) (
    input  logic clk,
    input  logic reset_x,
    input  logic i_line_n,
    input  logic i_clr,
    output logic o_pending
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [SYNC_STAGES-1:0] r_fill;
    logic                   r_last;
    logic                   r_pend;
    logic                   w_synced;
    logic                   w_fall;

    assign w_synced = r_sync[SYNC_STAGES-1];

    // r_fill marks when the last sync stage holds a real sample rather than
    // its reset value, so a line held low through reset is not seen as a fall.
    assign w_fall = r_last & ~w_synced;

    // Synchroniser chain and fill tracker
    always_ff @(posedge clk or negedge reset_x) begin
        if (!reset_x) begin
            r_sync <= '1;
            r_fill <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_line_n};
            r_fill <= {r_fill[SYNC_STAGES-2:0], 1'b1};
        end
    end

    // Edge detector history: only a genuine synced high arms the detector
    always_ff @(posedge clk or negedge reset_x) begin
        if (!reset_x) begin
            r_last <= 1'b0;
        end else begin
            r_last <= w_synced & r_fill[SYNC_STAGES-1];
        end
    end

    // Edge-pending bit: a new fall wins over a same-cycle clear
    always_ff @(posedge clk or negedge reset_x) begin
        if (!reset_x) begin
            r_pend <= 1'b0;
        end else if (w_fall) begin
            r_pend <= 1'b1;
        end else if (i_clr) begin
            r_pend <= 1'b0;
        end
    end

    // Level lines simply follow the synchronised (inverted) pin
    assign o_pending = (MODE == LINE_EDGE) ? r_pend : ~w_synced;

endmodule
`default_nettype wire

// File: rtl/irq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : irq_ctrl
//  Description : Parametrised external interrupt controller. Synchronises
//                active-low lines, latches/masks pending bits, presents one
//                prioritised request with cause, and pulses IACK_n on take.
//  Revision    : 1.0 - initial release
// ============================================================================
module irq_ctrl
    import irq_ctrl_pkg::*;
#(
    parameter int                NUM_IRQ     = 3,
    parameter int                SYNC_STAGES = 2,
    parameter logic [NUM_IRQ-1:0] EDGE_MASK  = '1,
    parameter int                IACK_CYCLES = 1,
    parameter int unsigned       CAUSE_BASE  = c_CAUSE_BASE_DEFAULT,
    parameter int                CAUSE_W     = 5
) (
    input  logic               clk,
    input  logic               reset_x,
    input  logic [NUM_IRQ-1:0] OINT_n,
    input  logic               mie,
    input  logic [NUM_IRQ-1:0] irq_mask,
    input  logic [NUM_IRQ-1:0] clr_pending,
    input  logic               irq_take,
    output logic               irq_req,
    output logic [CAUSE_W-1:0] irq_cause,
    output logic [NUM_IRQ-1:0] irq_pending,
    output logic               IACK_n
);

    localparam int                  c_CNT_W      = $clog2(IACK_CYCLES + 1);
    localparam logic [c_CNT_W-1:0]  c_CNT_LOAD   = c_CNT_W'(IACK_CYCLES - 1);
    localparam logic [CAUSE_W-1:0]  c_CAUSE_BASE = CAUSE_W'(CAUSE_BASE);

    logic [1:0]         r_state;
    logic [c_SEL_W-1:0] r_sel;
    logic               r_req;
    logic [CAUSE_W-1:0] r_cause;
    logic               r_iack_n;
    logic [c_CNT_W-1:0] r_cnt;

    logic [NUM_IRQ-1:0] w_pending;
    logic [NUM_IRQ-1:0] w_clr;
    logic [NUM_IRQ-1:0] w_elig;
    logic [15:0]        w_elig16;
    logic [c_SEL_W-1:0] w_prio;
    logic               w_any;
    logic               w_take_fire;
    logic               w_withdraw;

    // Per-line synchroniser / pending logic; a take also clears the served line
    generate
        for (genvar i = 0; i < NUM_IRQ; i++) begin : g_line
            assign w_clr[i] = clr_pending[i] |
                              (w_take_fire & (r_sel == c_SEL_W'(i)));

            irq_ctrl_sync #(
                .SYNC_STAGES (SYNC_STAGES),
                .MODE        (EDGE_MASK[i] ? LINE_EDGE : LINE_LEVEL)
            ) u_sync (
                .clk       (clk),
                .reset_x   (reset_x),
                .i_line_n  (OINT_n[i]),
                .i_clr     (w_clr[i]),
                .o_pending (w_pending[i])
            );
        end
    endgenerate

    assign w_elig      = w_pending & irq_mask & {NUM_IRQ{mie}};
    assign w_elig16    = 16'(w_elig);
    assign w_any       = |w_elig;
    assign w_prio      = f_lowest_set(w_elig16);
    assign w_take_fire = (r_state == c_ST_REQ) & irq_take;
    // The frozen selection lost its eligibility (mask, mie or level release)
    assign w_withdraw  = ~w_elig16[r_sel];

    // Request / acknowledge FSM with registered outputs and IACK pulse counter
    always_ff @(posedge clk or negedge reset_x) begin
        if (!reset_x) begin
            r_state  <= c_ST_IDLE;
            r_sel    <= '0;
            r_req    <= 1'b0;
            r_cause  <= '0;
            r_iack_n <= 1'b1;
            r_cnt    <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_any) begin
                        r_state <= c_ST_REQ;
                        r_sel   <= w_prio;
                        r_req   <= 1'b1;
                        r_cause <= c_CAUSE_BASE + CAUSE_W'(w_prio);
                    end
                end
                c_ST_REQ: begin
                    // Selection is frozen here; take beats withdraw
                    if (irq_take) begin
                        r_state  <= c_ST_ACK;
                        r_req    <= 1'b0;
                        r_iack_n <= 1'b0;
                        r_cnt    <= c_CNT_LOAD;
                    end else if (w_withdraw) begin
                        r_state <= c_ST_IDLE;
                        r_req   <= 1'b0;
                    end
                end
                c_ST_ACK: begin
                    if (r_cnt == '0) begin
                        r_state  <= c_ST_IDLE;
                        r_iack_n <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - c_CNT_W'(1);
                    end
                end
                default: begin
                    r_state  <= c_ST_IDLE;
                    r_req    <= 1'b0;
                    r_iack_n <= 1'b1;
                end
            endcase
        end
    end

    assign irq_req     = r_req;
    assign irq_cause   = r_cause;
    assign irq_pending = w_pending;
    assign IACK_n      = r_iack_n;

endmodule
`default_nettype wire
